// File: rtl/expr_spawner_if.sv
// Bundles the spawner's control inputs and expression outputs.
// The spawner is the master; the game logic consuming expressions is the slave.
interface expr_spawner_if;
  logic        enable;
  logic [6:0]  score;
  logic [11:0] tmp_exp;
  logic [1:0]  line;
  logic        update;

  modport master (input enable, score, output tmp_exp, line, update);
  modport slave  (output enable, score, input tmp_exp, line, update);
endinterface

// File: rtl/expr_spawner.sv
// Periodically spawns a random arithmetic expression {a, op, b} into one of three lanes.
// Optional score-driven speed-up is enabled by defining SPAWN_SPEEDUP_EN.
module expr_spawner #(
  parameter int          PERIOD_BASE = 64,
  parameter int          PERIOD_MIN  = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic          delay_clk,
  input logic          rst,
  expr_spawner_if.master bus
);

  localparam int CW = $clog2(PERIOD_BASE + 1);

  logic [15:0]   lfsr;
  logic [CW-1:0] counter;
  logic [CW-1:0] period;
  logic [CW-1:0] next_period;
  logic [11:0]   exp_q;
  logic [1:0]    line_q;
  logic          update_q;

  logic [3:0] ra, rb, op, a, b;
  logic [1:0] lane;
  logic       feedback;

`ifdef SPAWN_SPEEDUP_EN
  // Shortening is done in 32-bit space so a large score clamps to the floor instead of wrapping.
  logic [31:0] speed_cut;
  always_comb begin
    speed_cut = {25'd0, bus.score[6:2], 2'b00};
    if (speed_cut + 32'(PERIOD_MIN) >= 32'(PERIOD_BASE))
      next_period = CW'(PERIOD_MIN);
    else
      next_period = CW'(32'(PERIOD_BASE) - speed_cut);
  end
`else
  assign next_period = CW'(PERIOD_BASE);
`endif

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Subtraction and division swap operands so results stay non-negative and divisors nonzero.
  always_comb begin
    ra = (lfsr[7:4] % 4'd9) + 4'd1;
    rb = (lfsr[11:8] % 4'd9) + 4'd1;
    op = 4'hA + {2'b00, lfsr[13:12]};
    a  = ra;
    b  = rb;
    if ((op == 4'hB || op == 4'hD) && ra < rb) begin
      a = rb;
      b = ra;
    end
    if (lfsr[15:14] == 2'd3)
      lane = (line_q == 2'd2) ? 2'd0 : line_q + 2'd1;
    else
      lane = lfsr[15:14];
  end

  always_ff @(posedge delay_clk or negedge rst) begin
    if (!rst) begin
      lfsr     <= SEED;
      counter  <= '0;
      period   <= CW'(PERIOD_BASE);
      exp_q    <= 12'h000;
      line_q   <= 2'd2;
      update_q <= 1'b0;
    end else begin
      lfsr     <= {lfsr[14:0], feedback};
      update_q <= 1'b0;
      if (bus.enable) begin
        if (counter == period - CW'(1)) begin
          counter  <= '0;
          period   <= next_period;
          exp_q    <= {a, op, b};
          line_q   <= lane;
          update_q <= 1'b1;
        end else begin
          counter <= counter + CW'(1);
        end
      end
    end
  end

  assign bus.tmp_exp = exp_q;
  assign bus.line    = line_q;
  assign bus.update  = update_q;

endmodule

// File: doc/expr_spawner.md
EXPR_SPAWNER -- requirements
Module: expr_spawner

Interface
REQ-001 SHALL have parameter PERIOD_BASE, default 64, delay_clk cycles between spawns at score 0.
REQ-002 SHALL have parameter PERIOD_MIN, default 16, floor on spawn period.
REQ-003 SHALL have parameter SEED, default 16'hACE1, LFSR reset value; nonzero.
REQ-004 SHALL have port delay_clk  input  1  game clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  spawning allowed; low freezes period counter.
REQ-007 SHALL have port score  input  7  current score; drives speed-up.
REQ-008 SHALL have port tmp_exp  output  12  expression {a[3:0], op[3:0], b[3:0]}; registered.
REQ-009 SHALL have port line  output  2  target lane 0..2; registered.
REQ-010 SHALL have port update  output  1  one-cycle spawn strobe; registered.

Function
REQ-011 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle regardless of enable.
REQ-012 SHALL count cycles in a period counter 0..period-1 while enable=1; hold when enable=0.
REQ-013 SHALL, on the edge where counter==period-1 and enable=1, reset counter to 0, assert update=1 and load tmp_exp and line, all on that same edge.
REQ-014 SHALL drive update=1 for exactly one cycle; update=0 on every other edge, including all edges with enable=0.
REQ-015 SHALL hold tmp_exp and line unchanged between spawns.
REQ-016 SHALL derive raw operands ra=(lfsr[7:4] mod 9)+1 and rb=(lfsr[11:8] mod 9)+1, range 1..9.
REQ-017 SHALL set op=4'hA+lfsr[13:12], giving A add, B sub, C mul, D div; tmp_exp is therefore never 12'h000.
REQ-018 SHALL, for op B or D with ra<rb, swap operands so a>=b; results stay non-negative and divisor is nonzero.
REQ-019 SHALL set line=lfsr[15:14] when that value is 0..2; when it is 3, set line=(previous line+1) mod 3.
REQ-020 SHALL load the active period at each spawn and at reset, and SHALL NOT change it mid-count.
REQ-021 SHALL treat enable falling mid-count as a pause: the count resumes from the held value when enable returns high.
REQ-022 SHALL ignore score changes between spawns; score is sampled only per REQ-020.

Reset
REQ-023 SHALL, while rst=0, force lfsr=SEED, counter=0, period=PERIOD_BASE, tmp_exp=12'h000, line=2'd2, update=0.
REQ-024 SHALL, on rst assertion mid-period, abort the count with no spawn, and SHALL emit the first post-release update on the PERIOD_BASE-th rising edge with enable=1.

Configuration
REQ-025 SHALL, with SPAWN_SPEEDUP_EN defined, set period=max(PERIOD_MIN, PERIOD_BASE-4*score[6:2]), computed without unsigned wrap.
REQ-026 SHALL, without SPAWN_SPEEDUP_EN, fix period=PERIOD_BASE, leave score unused, and omit the speed-up logic.

Verification
REQ-027 SHALL check: PERIOD_BASE=64, enable=1, score=0, reset release -> first update on edge 64, then every 64 edges; each update exactly 1 cycle wide.
REQ-028 SHALL check: 10000 spawns -> tmp_exp[7:4] in A..D; a,b in 1..9; for B/D a>=b; line never 3.
REQ-029 SHALL check: enable low for 20 cycles at counter=30 -> no update; next update 34 enabled cycles after enable returns.
REQ-030 SHALL check, with SPAWN_SPEEDUP_EN defined: score=20 -> period 44; score=127 -> period 16; score changed mid-period -> new period applied only after the next spawn.
REQ-031 SHALL check, without SPAWN_SPEEDUP_EN: score=127 -> period stays 64.
REQ-032 SHALL check: rst pulsed low at counter=50 -> all outputs at reset values, lfsr=16'hACE1, next update 64 edges after release.
